// File: rtl/uart_tx_datafifo.sv
// First-word-fall-through transmit FIFO for the UART-lite TX path.
// Optional occupancy output port data_count enabled by `UART_TX_DATAFIFO_COUNT_EN.
module uart_tx_datafifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                      clk,
   input  logic                      srst,
   input  logic [DATA_WIDTH-1:0]     din,
   input  logic                      wr_en,
   input  logic                      rd_en,
   output logic [DATA_WIDTH-1:0]     dout,
   output logic                      full,
`ifdef UART_TX_DATAFIFO_COUNT_EN
   output logic [$clog2(DEPTH):0]    data_count,
`endif
   output logic                      empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;
   logic                  wr_ok;
   logic                  rd_ok;

   // Requests are qualified by the flags as they stood at the edge, so a
   // write while full or a read while empty is silently dropped.
   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);
   assign dout  = empty ? '0 : mem[rd_ptr];

`ifdef UART_TX_DATAFIFO_COUNT_EN
   assign data_count = count;
`endif

   // Storage has no reset; a reset only rewinds the pointers.
   always_ff @(posedge clk) begin
      if (!srst && wr_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_datafifo.sv
// Scoreboard bench for uart_tx_datafifo: a queue models the FIFO contents and
// every popped head word is compared against the front of the queue.
module tb_uart_tx_datafifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          srst;
   logic [DW-1:0] din;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] dout;
   logic          full;
   logic          empty;
`ifdef UART_TX_DATAFIFO_COUNT_EN
   logic [4:0]    data_count;
`endif

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] sb [$];
   logic [DW-1:0] last_pop;
   logic [DW-1:0] head_seen;
   logic          pop_valid;

   uart_tx_datafifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .srst       (srst),
      .din        (din),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .dout       (dout),
      .full       (full),
`ifdef UART_TX_DATAFIFO_COUNT_EN
      .data_count (data_count),
`endif
      .empty      (empty)
   );

   always #5 clk = ~clk;

   // One clock of stimulus; the model decides acceptance from its own occupancy.
   task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
      logic will_w;
      logic will_r;
      wr_en     = w;
      din       = d;
      rd_en     = r;
      head_seen = dout;
      will_r    = r && (sb.size() != 0);
      will_w    = w && (sb.size() != DEPTH);
      pop_valid = will_r;
      if (will_r) last_pop = sb.pop_front();
      if (will_w) sb.push_back(d);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      srst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      srst = 1'b0;
      sb.delete();
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
      checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout: got %h expected 00", dout); end
`ifdef UART_TX_DATAFIFO_COUNT_EN
      checks++; if (data_count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", data_count); end
`endif
   endtask

   task automatic test_single_word();
      step(1'b1, 8'hA5, 1'b0);
      checks++; if (empty !== 1'b0) begin errors++; $display("[TB] FAIL single_empty: got %b expected 0", empty); end
      checks++; if (dout !== 8'hA5) begin errors++; $display("[TB] FAIL single_dout: got %h expected a5", dout); end
      step(1'b0, 8'h00, 1'b1);
      checks++; if (!pop_valid || head_seen !== last_pop) begin errors++; $display("[TB] FAIL single_pop: got %h expected %h", head_seen, last_pop); end
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL single_empty_after: got %b expected 1", empty); end
      checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL single_dout_after: got %h expected 00", dout); end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, DW'(i), 1'b0);
         checks++; if (full !== (sb.size() == DEPTH)) begin errors++; $display("[TB] FAIL fill_full[%0d]: got %b expected %b", i, full, sb.size() == DEPTH); end
      end
      step(1'b1, 8'hFF, 1'b0);
      checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL overflow_full: got %b expected 1", full); end
      checks++; if (dout !== sb[0]) begin errors++; $display("[TB] FAIL overflow_head: got %h expected %h", dout, sb[0]); end
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 8'h00, 1'b1);
         checks++; if (!pop_valid || head_seen !== last_pop) begin errors++; $display("[TB] FAIL drain_order[%0d]: got %h expected %h", i, head_seen, last_pop); end
         checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL drain_full[%0d]: got %b expected 0", i, full); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_empty: got %b expected 1", empty); end
      checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL drain_dout: got %h expected 00", dout); end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h10 + i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, DW'(8'h13 + i), 1'b1);
         checks++; if (!pop_valid || head_seen !== last_pop) begin errors++; $display("[TB] FAIL simul_order[%0d]: got %h expected %h", i, head_seen, last_pop); end
         checks++; if (full !== 1'b0 || empty !== 1'b0) begin errors++; $display("[TB] FAIL simul_flags[%0d]: got full=%b empty=%b expected 0 0", i, full, empty); end
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'h00, 1'b1);
         checks++; if (!pop_valid || head_seen !== last_pop) begin errors++; $display("[TB] FAIL simul_drain[%0d]: got %h expected %h", i, head_seen, last_pop); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL simul_empty: got %b expected 1", empty); end
   endtask

   task automatic test_empty_simul();
      step(1'b1, 8'h3C, 1'b1);
      checks++; if (empty !== 1'b0) begin errors++; $display("[TB] FAIL empty_rw_empty: got %b expected 0", empty); end
      checks++; if (dout !== 8'h3C) begin errors++; $display("[TB] FAIL empty_rw_dout: got %h expected 3c", dout); end
      step(1'b0, 8'h00, 1'b1);
      checks++; if (!pop_valid || head_seen !== last_pop) begin errors++; $display("[TB] FAIL empty_rw_pop: got %h expected %h", head_seen, last_pop); end
   endtask

   task automatic test_full_simul();
      for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(8'h40 + i), 1'b0);
      checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL full_rw_pre: got %b expected 1", full); end
      step(1'b1, 8'hEE, 1'b1);
      checks++; if (!pop_valid || head_seen !== last_pop) begin errors++; $display("[TB] FAIL full_rw_pop: got %h expected %h", head_seen, last_pop); end
      checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL full_rw_full: got %b expected 0", full); end
      checks++; if (dout !== sb[0]) begin errors++; $display("[TB] FAIL full_rw_head: got %h expected %h", dout, sb[0]); end
      for (int i = 0; i < DEPTH - 1; i++) begin
         step(1'b0, 8'h00, 1'b1);
         checks++; if (!pop_valid || head_seen !== last_pop) begin errors++; $display("[TB] FAIL full_rw_drain[%0d]: got %h expected %h", i, head_seen, last_pop); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL full_rw_empty: got %b expected 1", empty); end
   endtask

   task automatic test_underflow();
      step(1'b0, 8'h00, 1'b1);
      checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL underflow_flags: got empty=%b full=%b expected 1 0", empty, full); end
      checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL underflow_dout: got %h expected 00", dout); end
      step(1'b1, 8'h77, 1'b0);
      checks++; if (dout !== 8'h77) begin errors++; $display("[TB] FAIL underflow_next: got %h expected 77", dout); end
      step(1'b0, 8'h00, 1'b1);
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL underflow_drain: got %b expected 1", empty); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h60 + i), 1'b0);
      srst  = 1'b1;
      wr_en = 1'b1;
      din   = 8'h99;
      @(posedge clk);
      #1;
      srst  = 1'b0;
      wr_en = 1'b0;
      sb.delete();
      checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags: got empty=%b full=%b expected 1 0", empty, full); end
      checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL midreset_dout: got %h expected 00", dout); end
`ifdef UART_TX_DATAFIFO_COUNT_EN
      checks++; if (data_count !== 5'd0) begin errors++; $display("[TB] FAIL midreset_count: got %0d expected 0", data_count); end
`endif
      step(1'b1, 8'h5A, 1'b0);
      checks++; if (dout !== 8'h5A) begin errors++; $display("[TB] FAIL midreset_write: got %h expected 5a", dout); end
      step(1'b0, 8'h00, 1'b1);
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL midreset_drain: got %b expected 1", empty); end
   endtask

   initial begin
      srst  = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      din   = '0;
      #1;
      test_reset();
      test_single_word();
      test_fill_overflow();
      test_simultaneous();
      test_empty_simul();
      test_full_simul();
      test_underflow();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
